// File: rtl/arch_reg_read_arbiter_if.sv
// Architectural register read port between the read arbiter (master) and
// the CPU top-level read port (slave).
`ifndef ARCH_REG_NUM_WIDTH
`define ARCH_REG_NUM_WIDTH 5
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

interface arch_reg_read_arbiter_if #(
  parameter int ADDR_W = `ARCH_REG_NUM_WIDTH,
  parameter int DATA_W = `REG_VAL_WIDTH
);
  logic              rd_en;
  logic [ADDR_W-1:0] read_red_addr_req;
  logic              read_valid;
  logic [DATA_W-1:0] read_value;

  modport master (
    output rd_en,
    output read_red_addr_req,
    input  read_valid,
    input  read_value
  );

  modport slave (
    input  rd_en,
    input  read_red_addr_req,
    output read_valid,
    output read_value
  );
endinterface

// File: rtl/arch_reg_read_arbiter.sv
// Shares the single architectural register read port between NUM_REQ
// requesters. One read in flight at a time: accept, issue, respond.
//
// Optional feature macro: ARCH_REG_READ_ARB_RR_EN
//   defined   -> round-robin arbitration with a rotating priority pointer
//   undefined -> fixed priority, lowest requester index wins
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; req_ready shows the arbitration winner
// ISSUE | rd_en held high with the captured address until read_valid
// RESP  | one-cycle rsp_valid pulse to the granted requester, rd_en low
`ifndef ARCH_REG_NUM_WIDTH
`define ARCH_REG_NUM_WIDTH 5
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

module arch_reg_read_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = `ARCH_REG_NUM_WIDTH,
  parameter int DATA_W  = `REG_VAL_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  arch_reg_read_arbiter_if.master   rd
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                accept;
  logic                done;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [ADDR_W-1:0]   win_addr;
  logic [IDX_W-1:0]    grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic                rd_en_q;
  logic                busy_q;

`ifdef ARCH_REG_READ_ARB_RR_EN
  logic [IDX_W-1:0]    ptr_q;
`endif

  // Pick the winner among asserted requests, scanning from the priority start.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_addr  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
`ifdef ARCH_REG_READ_ARB_RR_EN
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
`else
      j = k;
`endif
      if (!win_found && req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
        win_addr  = req_addr[j*ADDR_W +: ADDR_W];
      end
    end
  end

  // Next-state and combinational grant; only IDLE ever presents req_ready.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          accept    = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (rd.read_valid) begin
          done    = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Captured grant/address, read data and the registered port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= '0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (accept) begin
        grant_q <= win_idx;
        addr_q  <= win_addr;
        rd_en_q <= 1'b1;
        busy_q  <= 1'b1;
      end
      if (done) begin
        data_q      <= rd.read_value;
        rd_en_q     <= 1'b0;
        rsp_valid_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
      end
      if (state_q == RESP) busy_q <= 1'b0;
    end
  end

`ifdef ARCH_REG_READ_ARB_RR_EN
  // Rotate priority to the requester after the one just accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + IDX_W'(1);
    end
  end
`endif

  assign rsp_valid            = rsp_valid_q;
  assign rsp_data             = data_q;
  assign busy                 = busy_q;
  assign rd.rd_en             = rd_en_q;
  assign rd.read_red_addr_req = addr_q;

endmodule

// File: doc/arch_reg_read_arbiter.md
# arch_reg_read_arbiter

Shares the single architectural register read port (ARCH_REG_READ_IF, slave side inside CPU) between NUM_REQ requesters, for example the debug regfile-dump engine and the commit checker. The block accepts one request at a time and drives rd_en/read_red_addr_req to the CPU. It waits for read_valid, then returns read_value to the granted requester. It sits between the debug requesters and the CPU top-level read port.

## Interface
- NUM_REQ, 2: number of requesters, 2..8.
- ADDR_W, `ARCH_REG_NUM_WIDTH: arch register index width.
- DATA_W, `REG_VAL_WIDTH: register value width.
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*ADDR_W  per-requester register index; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  one-hot grant; a request is accepted in a cycle where req_valid[i] and req_ready[i] are both high.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse to the requester that was served.
- rsp_data  out  DATA_W  read value; valid only while any rsp_valid bit is high.
- busy  out  1  high in ISSUE and RESP.
- rd_en  out  1  to ARCH_REG_READ_IF.rd_en.
- read_red_addr_req  out  ADDR_W  to ARCH_REG_READ_IF.read_red_addr_req.
- read_valid  in  1  from ARCH_REG_READ_IF.read_valid.
- read_value  in  DATA_W  from ARCH_REG_READ_IF.read_value.

## Operation
- FSM states are IDLE, ISSUE and RESP.
- IDLE:
  - req_ready is combinationally the arbitration winner among the asserted req_valid bits; it is 0 if none are asserted.
  - On acceptance, the block registers the grant index and req_addr of the winner, then moves to ISSUE.
- ISSUE:
  - rd_en=1 and read_red_addr_req=captured address, both held stable.
  - On read_valid=1, the block captures read_value into rsp_data and moves to RESP.
- RESP:
  - rsp_valid[grant]=1 for exactly one cycle and rd_en=0; the FSM then returns to IDLE.
  - rd_en is therefore low for at least one cycle between reads, which is required by the CPU read port.
- Arbitration is round-robin (see Configuration). The priority pointer is updated on acceptance to (grant+1) mod NUM_REQ.
- req_ready is all-zero outside IDLE. Requests that arrive while the block is busy are held by the requester and are not lost.
- req_addr changes after acceptance have no effect because the address was captured.
- read_valid is ignored in IDLE and RESP.
- Reset:
  - rd_en=0, read_red_addr_req=0, req_ready=0, rsp_valid=0, rsp_data=0, busy=0.
  - FSM=IDLE and priority pointer=0.
- Reset asserted mid-ISSUE aborts the read: rd_en drops the cycle after reset is sampled, and no rsp_valid is produced.
- Simultaneous req_valid from several requesters results in a grant to exactly one; the others wait.

## Timing
- Cycle 0: request accepted (IDLE, req_valid & req_ready).
- Cycle 1: rd_en=1 with the address (ISSUE).
- Cycle k≥1: read_valid is first sampled high.
- Cycle k+1: rsp_valid pulse with rsp_data, rd_en=0.
- Cycle k+2: IDLE; the next request can be accepted.
- Minimum turnaround is 3 cycles per read, with read_valid sampled in cycle 1.
- All outputs are registered except req_ready, which is combinational from req_valid and the FSM state.

## Configuration
- ARCH_REG_READ_ARB_RR_EN defined: round-robin arbitration using the rotating priority pointer described above.
- ARCH_REG_READ_ARB_RR_EN undefined: fixed priority, where the lowest index wins. The pointer register is removed, and requester 0 can starve the others.

## Test plan
- Single read: req_valid=01, req_addr[0]=5, and read_valid driven 2 cycles after rd_en with read_value=0xDEADBEEF → rd_en high exactly 2 cycles with addr 5, then rsp_valid=01 for one cycle with rsp_data=0xDEADBEEF, busy deasserted the following cycle.
- Contention, RR enabled: both requesters hold req_valid with addrs 3 and 7 for 4 reads → grants alternate 0,1,0,1, and each rsp_data matches the model regfile value for its address.
- Contention, RR disabled: the same stimulus → requester 0 is granted all 4 times and requester 1 is never granted while req_valid[0] stays high.
- Regfile dump: requester 1 reads regs 0..31 sequentially, with the CPU model returning reg*0x11 → 32 responses in order with the correct values and rd_en low for ≥1 cycle between each read.
- Reset mid-read: reset asserted for 1 cycle while in ISSUE, with read_valid never asserted → rd_en=0 and busy=0 the next cycle, no rsp_valid, and the next request is served normally from pointer 0.
- Stray read_valid: read_valid pulsed in IDLE → no rsp_valid and no state change.
